// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encoding and arm-length helper.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Cycles after reset release before detection is trusted; long enough to flush sync and filter.
  function automatic int unsigned arm_len(input int unsigned sync_stages,
                                          input int unsigned deb_cycles,
                                          input bit          deb_en);
    return sync_stages + 1 + (deb_en ? deb_cycles : 0);
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One edge-detector channel: synchroniser, optional debounce filter, detection, toggle and counter.
// Debounce filter is built only when MULTI_EDGE_DEBOUNCE_EN is defined.
module edge_channel
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
`ifdef MULTI_EDGE_DEBOUNCE_EN
  , parameter int unsigned DEB_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             armed_i,
  input  logic             sig_i,
  input  logic [1:0]       mode_i,
  input  logic             clear_i,
  output logic             det_c,
  output logic             edge_o,
  output logic             toggle_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl_c;
  logic                   lvl_c;
  logic                   prev_q;
  logic                   edge_q;
  logic                   tog_q, tog_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   rise_en_c, fall_en_c;

  assign sync_lvl_c = sync_q[SYNC_STAGES-1];

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             filt_q, filt_d;

  // Filtered level follows the synced level only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    deb_cnt_d = '0;
    filt_d    = filt_q;
    if (sync_lvl_c != filt_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        filt_d = sync_lvl_c;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q <= '0;
      filt_q    <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      filt_q    <= filt_d;
    end
  end

  assign lvl_c = filt_q;
`else
  assign lvl_c = sync_lvl_c;
`endif

  assign rise_en_c = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
  assign fall_en_c = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);
  assign det_c     = armed_i & ((rise_en_c & lvl_c & ~prev_q) | (fall_en_c & ~lvl_c & prev_q));

  // clear wins over a coincident edge for toggle/counter state.
  always_comb begin
    tog_d = tog_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear_i) begin
      tog_d = 1'b0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (det_c) begin
      tog_d = ~tog_q;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX - CNT_W'(1)) begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      tog_q  <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q[0] <= sig_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= lvl_c;
      edge_q <= det_c;
      tog_q  <= tog_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign edge_o   = edge_q;
  assign toggle_o = tog_q;
  assign cnt_o    = cnt_q;
  assign sat_o    = sat_q;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector top: shared arm counter, any_edge register and per-channel bus packing.
// Define MULTI_EDGE_DEBOUNCE_EN to insert a DEB_CYCLES debounce filter in every channel.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEB_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       sig,
  input  logic [2*N_CH-1:0]     mode,
  input  logic                  clear,
  output logic [N_CH-1:0]       sig_edge,
  output logic [N_CH-1:0]       toggle,
  output logic [N_CH*CNT_W-1:0] edge_cnt,
  output logic [N_CH-1:0]       cnt_sat,
  output logic                  any_edge
);

`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  localparam int unsigned ARM_LEN = arm_len(SYNC_STAGES, DEB_CYCLES, DEB_EN);
  localparam int unsigned ARM_W   = $clog2(ARM_LEN + 1);

  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed_c;
  logic [N_CH-1:0]  det_c;
  logic             any_edge_q;

  assign armed_c = (arm_cnt_q == ARM_W'(ARM_LEN));

  // Arm counter saturates once armed; clear does not restart it.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (!armed_c) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt_q  <= '0;
      any_edge_q <= 1'b0;
    end else begin
      arm_cnt_q  <= arm_cnt_d;
      any_edge_q <= |det_c;
    end
  end

  assign any_edge = any_edge_q;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
`ifdef MULTI_EDGE_DEBOUNCE_EN
      , .DEB_CYCLES (DEB_CYCLES)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .armed_i  (armed_c),
      .sig_i    (sig[g]),
      .mode_i   (mode[2*g +: 2]),
      .clear_i  (clear),
      .det_c    (det_c[g]),
      .edge_o   (sig_edge[g]),
      .toggle_o (toggle[g]),
      .cnt_o    (edge_cnt[g*CNT_W +: CNT_W]),
      .sat_o    (cnt_sat[g])
    );
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Self-checking bench for multi_edge_detector: directed scenarios plus randomized traffic vs a delay-line model.
module tb_multi_edge_detector;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned SS    = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEB   = 4;
`ifdef MULTI_EDGE_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif
  localparam int ARM  = int'(SS) + 1 + (DEB_ON ? int'(DEB) : 0);
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int MAXC = 8000;
  localparam int HOLD = 6;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH-1:0]       sig;
  logic [2*N_CH-1:0]     mode;
  logic                  clear;
  logic [N_CH-1:0]       sig_edge;
  logic [N_CH-1:0]       toggle;
  logic [N_CH*CNT_W-1:0] edge_cnt;
  logic [N_CH-1:0]       cnt_sat;
  logic                  any_edge;

  multi_edge_detector #(
    .N_CH        (N_CH),
    .SYNC_STAGES (SS),
    .CNT_W       (CNT_W),
    .DEB_CYCLES  (DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sig      (sig),
    .mode     (mode),
    .clear    (clear),
    .sig_edge (sig_edge),
    .toggle   (toggle),
    .edge_cnt (edge_cnt),
    .cnt_sat  (cnt_sat),
    .any_edge (any_edge)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sig sampled per clock, synced level is simply a delayed copy of that history.
  logic [N_CH-1:0] hist [MAXC];
  logic [N_CH-1:0] lv   [MAXC];
  int t        = 0;
  int last_rst = 0;
  int m_cnt  [N_CH];
  bit m_tog  [N_CH];
  bit m_sat  [N_CH];
  bit m_edge [N_CH];
  bit m_filt [N_CH];
  int m_run  [N_CH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  function automatic bit seen(input int ch, input int tt);
    if (tt - int'(SS) > last_rst) return hist[tt - int'(SS)][ch];
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit s, l, p, det;
    t++;
    if (t >= MAXC) begin
      $display("FAIL model_overflow cycle=%0d", t);
      $fatal(1, "history exhausted");
    end
    hist[t] = sig;
    if (reset) begin
      last_rst = t;
      for (int c = 0; c < int'(N_CH); c++) begin
        m_cnt[c] = 0; m_tog[c] = 1'b0; m_sat[c] = 1'b0;
        m_edge[c] = 1'b0; m_filt[c] = 1'b0; m_run[c] = 0;
      end
      return;
    end
    for (int c = 0; c < int'(N_CH); c++) begin
      s = seen(c, t);
      if (DEB_ON) begin
        l = m_filt[c];
        if (s != m_filt[c]) begin
          m_run[c]++;
          if (m_run[c] == int'(DEB)) begin
            m_filt[c] = s;
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end else begin
        l = s;
      end
      lv[t][c] = l;
      p = (t - 1 > last_rst) ? lv[t-1][c] : 1'b0;
      det = (t - last_rst > ARM) &&
            ((mode[2*c] && l && !p) || (mode[2*c+1] && !l && p));
      m_edge[c] = det;
      if (clear) begin
        m_cnt[c] = 0; m_tog[c] = 1'b0; m_sat[c] = 1'b0;
      end else if (det) begin
        m_tog[c] = !m_tog[c];
        if (m_cnt[c] < CMAX) m_cnt[c]++;
        if (m_cnt[c] == CMAX) m_sat[c] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N_CH-1:0]       e_edge, e_tog, e_sat;
    logic [N_CH*CNT_W-1:0] e_cnt;
    for (int c = 0; c < int'(N_CH); c++) begin
      e_edge[c] = m_edge[c];
      e_tog[c]  = m_tog[c];
      e_sat[c]  = m_sat[c];
      e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
    end
    check("sig_edge", 64'(sig_edge), 64'(e_edge));
    check("toggle",   64'(toggle),   64'(e_tog));
    check("edge_cnt", 64'(edge_cnt), 64'(e_cnt));
    check("cnt_sat",  64'(cnt_sat),  64'(e_sat));
    check("any_edge", 64'(any_edge), 64'(|e_edge));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic pulse_train(input int ch, input int n, input int hold, output int seen_n);
    seen_n = 0;
    for (int i = 0; i < n; i++) begin
      sig[ch] = 1'b1;
      for (int k = 0; k < hold; k++) begin step(); seen_n += int'(sig_edge[ch]); end
      sig[ch] = 1'b0;
      for (int k = 0; k < hold; k++) begin step(); seen_n += int'(sig_edge[ch]); end
    end
    for (int k = 0; k < ARM + 2; k++) begin step(); seen_n += int'(sig_edge[ch]); end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  int npulse;
  int hold [N_CH];

  initial begin
    // Lines held high through reset must not produce a rising edge once armed.
    reset = 1'b1; clear = 1'b0; sig = '1; mode = 8'b01010101;
    repeat (3) step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("arm_quiet", 64'(sig_edge), 64'(0));
    end
    check("arm_cnt_zero", 64'(edge_cnt), 64'(0));
    check("arm_tog_zero", 64'(toggle), 64'(0));
    check("arm_sat_zero", 64'(cnt_sat), 64'(0));

    // Single rise on ch0: pulse appears after exactly ARM clocks, once.
    sig = '0;
    repeat (ARM + 4) step();
    do_clear();
    sig[0] = 1'b1;
    for (int k = 1; k <= ARM + 2; k++) begin
      step();
      check("rise_lat_edge", 64'(sig_edge), 64'((k == ARM) ? 4'b0001 : 4'b0000));
      check("rise_lat_any",  64'(any_edge), 64'((k == ARM) ? 1 : 0));
    end
    check("rise_cnt0", 64'(edge_cnt[0 +: CNT_W]), 64'(1));
    check("rise_tog",  64'(toggle), 64'(4'b0001));

    // Ch1 both edges: 10 pulses, then falling only: 5 more, landing exactly on saturation.
    mode = 8'b00001100;
    do_clear();
    pulse_train(1, 5, HOLD, npulse);
    check("both_pulses", 64'(npulse), 64'(10));
    check("both_cnt1",   64'(edge_cnt[CNT_W +: CNT_W]), 64'(10));
    check("both_tog1",   64'(toggle[1]), 64'(0));
    check("both_sat1",   64'(cnt_sat[1]), 64'(0));
    mode = 8'b00001000;
    pulse_train(1, 5, HOLD, npulse);
    check("fall_pulses", 64'(npulse), 64'(5));
    check("fall_cnt1",   64'(edge_cnt[CNT_W +: CNT_W]), 64'(CMAX));
    check("fall_sat1",   64'(cnt_sat[1]), 64'(1));

    // Ch2 overflow: counter sticks at all-ones, pulses continue, clear recovers.
    mode = 8'b00010000;
    do_clear();
    pulse_train(2, CMAX + 2, HOLD, npulse);
    check("sat_pulses", 64'(npulse), 64'(CMAX + 2));
    check("sat_cnt2",   64'(edge_cnt[2*CNT_W +: CNT_W]), 64'(CMAX));
    check("sat_flag2",  64'(cnt_sat[2]), 64'(1));
    do_clear();
    check("clr_cnt2", 64'(edge_cnt[2*CNT_W +: CNT_W]), 64'(0));
    check("clr_sat2", 64'(cnt_sat[2]), 64'(0));

    // clear in the detection cycle: pulse still fires, edge not counted or toggled.
    mode = 8'b00000001;
    sig[0] = 1'b0;
    repeat (ARM + 3) step();
    sig[0] = 1'b1;
    repeat (ARM - 1) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clrdet_edge", 64'(sig_edge[0]), 64'(1));
    check("clrdet_cnt0", 64'(edge_cnt[0 +: CNT_W]), 64'(0));
    check("clrdet_tog0", 64'(toggle[0]), 64'(0));

`ifdef MULTI_EDGE_DEBOUNCE_EN
    // Short glitch is filtered; a long pulse yields one rise and one fall.
    mode = 8'b11000000;
    sig[3] = 1'b0;
    repeat (ARM + 3) step();
    do_clear();
    pulse_train(3, 1, int'(DEB) - 1, npulse);
    check("deb_glitch", 64'(npulse), 64'(0));
    pulse_train(3, 1, HOLD, npulse);
    check("deb_pulse", 64'(npulse), 64'(2));
`endif

    // Randomized traffic with mode changes, clears and occasional resets.
    for (int c = 0; c < int'(N_CH); c++) hold[c] = int'($urandom_range(SS, 12));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < int'(N_CH); c++) begin
        if (hold[c] == 0) begin
          sig[c]  = ~sig[c];
          hold[c] = DEB_ON ? int'($urandom_range(0, 12)) : int'($urandom_range(SS, 12));
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      reset = reset ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    clear = 1'b0;
    repeat (ARM + 5) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised N-channel edge detector for asynchronous or slow control inputs such as triggers, strobes and handshake lines.
- Each channel has:
  - an input synchroniser
  - a per-channel runtime-selectable edge mode (rise / fall / both / off)
  - a one-cycle edge pulse
  - a toggle output
  - a saturating edge counter with a sticky saturation flag
- Sits between external pins or other clock domains and the control FSMs, which consume either pulses or counts.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- CNT_W, 8, width of each per-channel edge counter (>=1).
- DEB_CYCLES, 4, stable-cycle count required by the debounce filter (>=1; used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sig  in  N_CH  raw input lines; may be asynchronous to clk.
- mode  in  2*N_CH  per-channel edge select; channel i uses mode[2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- clear  in  1  synchronous pulse; zeroes all toggles, counters and saturation flags.
- sig_edge  out  N_CH  registered one-cycle pulse per detected edge.
- toggle  out  N_CH  inverts on every detected edge.
- edge_cnt  out  N_CH*CNT_W  per-channel counters; channel i occupies [i*CNT_W +: CNT_W].
- cnt_sat  out  N_CH  sticky flag: counter reached all-ones.
- any_edge  out  1  OR of sig_edge, registered in the same cycle as sig_edge.

Behaviour:
- Reset (synchronous, active-high):
  - Sync flops, previous-level register, sig_edge, toggle, edge_cnt, cnt_sat, any_edge and the arm counter all go to 0.
  - Reset asserted mid-operation discards any in-flight edge on the next clock.
- Synchroniser: sig[i] passes through SYNC_STAGES flops, giving the synced level s[i].
- Arming:
  - After reset deasserts, an arm counter runs for SYNC_STAGES+1 cycles.
  - While unarmed, prev[i] tracks s[i] but no edges are detected.
  - Consequence: a line held high through reset produces no spurious rising edge.
- Detection, at each clock while armed:
  - rise = s & ~prev; fall = ~s & prev.
  - det = (mode bit0 & rise) | (mode bit1 & fall).
  - prev <= s.
  - sig_edge <= det.
- Latency: a level change first captured at clock edge E0 drives sig_edge high during the cycle after edge E(SYNC_STAGES), for exactly one cycle.
- Mode:
  - Sampled on the same clock as detection; no pipeline.
  - A mode change takes effect on the next comparison.
  - Mode 00 suppresses pulses; toggle and counter hold.
- Toggle: toggle[i] <= ~toggle[i] on det[i].
- Counter:
  - edge_cnt[i] increments by 1 on det[i] and saturates at 2^CNT_W-1.
  - cnt_sat[i] sets when the counter becomes all-ones and stays set until clear or reset.
  - Further edges still pulse sig_edge and toggle; the counter holds.
- clear:
  - Has priority over a simultaneous det: toggle, counter and sat become 0 and that edge is not counted or toggled.
  - sig_edge still pulses for that edge.
  - Does not affect sync, prev or the arm counter.
- Toggling faster than one level per SYNC_STAGES+1 cycles is out of contract; missed edges are permitted, but no X or illegal state.

Optional Feature:
- Macro: MULTI_EDGE_DEBOUNCE_EN.
- Defined:
  - Per-channel filter between the synchroniser and detection.
  - Filtered level f[i] updates to s[i] only after s[i] differs from f[i] for DEB_CYCLES consecutive cycles.
  - The stability counter resets to 0 on any cycle where s[i] == f[i].
  - Adds DEB_CYCLES cycles of latency.
  - Arm time becomes SYNC_STAGES+DEB_CYCLES+1 cycles.
  - Reset loads f = 0 and clears the counter.
- Not defined: f = s, no extra logic or latency, and DEB_CYCLES is ignored.

Decomposition:
- Package edge_pkg:
  - Mode encoding constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11.
  - A function computing arm length from the parameters.
- Sub-module edge_channel:
  - One channel containing synchroniser, optional debounce, detection, toggle and counter.
  - Generate-instantiated N_CH times.
- Top level holds:
  - the shared arm counter
  - the any_edge OR register
  - the bus packing

Test Plan:
- Reset with sig=4'b1111 held, release after 3 cycles → no sig_edge for 10 cycles; all counts 0; toggle 0; cnt_sat 0.
- Mode=all 01, ch0 rises 0→1 at edge E0 → sig_edge[0] high for exactly 1 cycle after edge E2 (SYNC_STAGES=2); edge_cnt[0]=1; toggle[0]=1; any_edge coincident; other channels quiet.
- Ch1 mode=11, 5 full pulses (10 edges), each level 6 cycles → 10 sig_edge pulses; edge_cnt[1]=10; toggle[1]=0. Repeat with mode 10 → count increases by 5.
- CNT_W=3, 9 rising edges on ch2 → count sticks at 7; cnt_sat[2] set after the 7th edge; pulses continue. clear → count 0, sat 0.
- clear asserted in the cycle det fires → sig_edge pulses; count 0; toggle 0.
- With MULTI_EDGE_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle glitch on ch3 → no edge. A 6-cycle pulse → one rise and one fall, each delayed 4 extra cycles.
